// File: rtl/rns_coeff_streamer.sv
// Streams the N real parts out of the shared FFT BRAM RNS port. Reads are issued
// against credits so the output FIFO can never overflow, whatever out_ready does.
module rns_coeff_streamer #(
  parameter int LOGN         = 13,
  parameter int FLP_WORDSIZE = 64,
  parameter int BRAM_RD_LAT  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [LOGN-1:0]         rns_rd_addr,
  input  logic [FLP_WORDSIZE-1:0] rns_rd_data,
  output logic [FLP_WORDSIZE-1:0] out_data,
  output logic [LOGN-1:0]         out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LOGN-1:0] LAST_IDX = '1;
  localparam logic [PW-1:0]   PTR_MAX  = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]              state;
  logic [LOGN-1:0]         cnt;
  logic [LOGN-1:0]         addr_q;
  logic [BRAM_RD_LAT-1:0]  vld_p;
  logic [LOGN-1:0]         idx_p [BRAM_RD_LAT];
  logic [FLP_WORDSIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [LOGN-1:0]         fifo_idx [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt;
  logic                    done_q;
  logic                    start_ok, credit_ok, issue, push, pop;
  int                      inflight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Credits count reads already in the BRAM pipe as if they occupied a FIFO slot.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < BRAM_RD_LAT; i++) begin
      if (vld_p[i]) inflight = inflight + 1;
    end
  end

  assign credit_ok = (inflight + int'(fifo_cnt) + 1) <= FIFO_DEPTH;
  // done_q blocks a restart in the cycle the FSM is still leaving DRAIN.
  assign start_ok  = (state == S_IDLE) && start && !done_q;
  assign issue     = credit_ok && (start_ok || (state == S_ISSUE));
  assign push      = vld_p[BRAM_RD_LAT-1];
  assign pop       = out_valid && out_ready;

  assign rns_rd_addr = issue ? cnt : addr_q;
  assign out_valid   = (fifo_cnt != '0);
  assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_index   = out_valid ? fifo_idx[rd_ptr] : '0;
  assign out_last    = out_valid && (fifo_idx[rd_ptr] == LAST_IDX);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      vld_p    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        addr_q <= cnt;
        if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
      end
      case (state)
        S_IDLE:  if (start_ok) state <= S_ISSUE;
        S_ISSUE: if (issue && (cnt == LAST_IDX)) state <= S_DRAIN;
        S_DRAIN: if (pop && out_last) begin
          state  <= S_IDLE;
          cnt    <= '0;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      vld_p[0] <= issue;
      for (int i = 1; i < BRAM_RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Read pipe stage boundary: index rides alongside its valid until the data lands.
  always_ff @(posedge clk) begin
    idx_p[0] <= cnt;
    for (int i = 1; i < BRAM_RD_LAT; i++) idx_p[i] <= idx_p[i-1];
    if (push) begin
      fifo_data[wr_ptr] <= rns_rd_data;
      fifo_idx[wr_ptr]  <= idx_p[BRAM_RD_LAT-1];
    end
  end

endmodule
